// File: rtl/coin_acceptor_if.sv
// Coin acceptor handshake bundle: raw sensors and dispense feedback in, clean coin codes out.
interface coin_acceptor_if;
  logic       sense_one;
  logic       sense_two;
  logic       bottle;
  logic [1:0] coin;
  logic       coin_return;
  logic       busy;

  modport master (
    output sense_one, sense_two, bottle,
    input  coin, coin_return, busy
  );

  modport slave (
    input  sense_one, sense_two, bottle,
    output coin, coin_return, busy
  );
endinterface

// File: rtl/coin_acceptor.sv
// Coin sensor synchroniser/debouncer producing one registered coin code or reject pulse per coin.
// Optional feature macro: COIN_ACCEPTOR_TWO_DOLLAR_EN (two-dollar coins accepted instead of returned).
module coin_acceptor #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES      = 2
) (
  input logic            clk,
  input logic            rst,
  coin_acceptor_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DEB, REL, GAP} state_t;

  localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  state_t     state_q, state_d;
  logic [1:0] s1_q, s1_d;
  logic [1:0] s2_q, s2_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] gap_q, gap_d;
  logic       typ_q, typ_d;
  logic [1:0] coin_q, coin_d;
  logic       ret_q, ret_d;
  logic       busy_q, busy_d;

  logic one, two, lat, oth;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  always_comb begin
    s1_d    = {bus.sense_two, bus.sense_one};
    s2_d    = s1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    typ_d   = typ_q;
    coin_d  = '0;
    ret_d   = 1'b0;
    one     = s2_q[0];
    two     = s2_q[1];
    lat     = typ_q ? two : one;
    oth     = typ_q ? one : two;

    case (state_q)
      IDLE: begin
        if (one && two) begin
          ret_d   = 1'b1;
          cnt_d   = '0;
          state_d = REL;
        end else if (one || two) begin
          typ_d   = two;
          cnt_d   = 4'd1;
          state_d = DEB;
        end
      end
      DEB: begin
        if (lat && !oth) begin
          if (cnt_q == DEB_LAST) begin
            // bottle only matters on this accept edge
            if (bus.bottle) begin
              ret_d = 1'b1;
            end else if (typ_q) begin
`ifdef COIN_ACCEPTOR_TWO_DOLLAR_EN
              coin_d = 2'd2;
`else
              ret_d = 1'b1;
`endif
            end else begin
              coin_d = 2'd1;
            end
            cnt_d   = '0;
            state_d = REL;
          end else begin
            cnt_d = sat_inc(cnt_q);
          end
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      REL: begin
        if (one || two) begin
          cnt_d = '0;
        end else if (cnt_q == DEB_LAST) begin
          cnt_d   = '0;
          gap_d   = '0;
          state_d = GAP;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_d = sat_inc(gap_q);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s1_q    <= '0;
      s2_q    <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      typ_q   <= 1'b0;
      coin_q  <= '0;
      ret_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      typ_q   <= typ_d;
      coin_q  <= coin_d;
      ret_q   <= ret_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.coin        = coin_q;
  assign bus.coin_return = ret_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed self-checking bench for coin_acceptor with default DEBOUNCE_CYCLES=4, GAP_CYCLES=2.
module tb_coin_acceptor;

  logic clk = 1'b0;
  logic rst = 1'b1;

  coin_acceptor_if bus();

  coin_acceptor #(.DEBOUNCE_CYCLES(4), .GAP_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Edge-indexed event log, sampled just after each rising edge.
  int n_one = 0, n_two = 0, n_ret = 0, viol = 0;
  int last_coin = -1, last_ret = -1;
  always @(posedge clk) begin
    #1;
    if (bus.coin == 2'd1) begin n_one++; last_coin = cyc; end
    if (bus.coin == 2'd2) begin n_two++; last_coin = cyc; end
    if (bus.coin_return)  begin n_ret++; last_ret  = cyc; end
    if (bus.coin == 2'd3 || (bus.coin != 2'd0 && bus.coin_return)) viol++;
  end

  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic to_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  int t0, b1, b2, br;

  task automatic start(output int t);
    @(negedge clk);
    b1 = n_one; b2 = n_two; br = n_ret;
    t  = cyc + 1;
  endtask

  initial begin
    bus.sense_one = 1'b0;
    bus.sense_two = 1'b0;
    bus.bottle    = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_coin", int'(bus.coin), 0);
    check("rst_ret",  int'(bus.coin_return), 0);
    check("rst_busy", int'(bus.busy), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Clean one-dollar coin, 12 cycles
    start(t0);
    bus.sense_one = 1'b1;
    to_cyc(t0 + 1);  check("clean_busy_t1", int'(bus.busy), 0);
    to_cyc(t0 + 2);  check("clean_busy_t2", int'(bus.busy), 1);
    to_cyc(t0 + 11); bus.sense_one = 1'b0;
    to_cyc(t0 + 18); check("clean_busy_gap", int'(bus.busy), 1);
    to_cyc(t0 + 19); check("clean_busy_fall", int'(bus.busy), 0);
    to_cyc(t0 + 30);
    check("clean_count", n_one - b1, 1);
    check("clean_latency", last_coin - t0, 5);
    check("clean_noret", n_ret - br, 0);

    // Glitch: two samples only
    start(t0);
    bus.sense_one = 1'b1;
    to_cyc(t0 + 1);  bus.sense_one = 1'b0;
    to_cyc(t0 + 3);  check("glitch_busy_deb", int'(bus.busy), 1);
    to_cyc(t0 + 4);  check("glitch_busy_idle", int'(bus.busy), 0);
    to_cyc(t0 + 20);
    check("glitch_nocoin", n_one - b1, 0);
    check("glitch_noret", n_ret - br, 0);

    // Bottle high across accept edge
    start(t0);
    bus.sense_one = 1'b1;
    bus.bottle    = 1'b1;
    to_cyc(t0 + 10); bus.bottle = 1'b0;
    to_cyc(t0 + 11); bus.sense_one = 1'b0;
    to_cyc(t0 + 30);
    check("bottle_ret", n_ret - br, 1);
    check("bottle_ret_time", last_ret - t0, 5);
    check("bottle_nocoin", n_one - b1, 0);

    // Bottle high only before the accept edge has no effect
    start(t0);
    bus.sense_one = 1'b1;
    bus.bottle    = 1'b1;
    to_cyc(t0 + 3);  bus.bottle = 1'b0;
    to_cyc(t0 + 11); bus.sense_one = 1'b0;
    to_cyc(t0 + 30);
    check("bottle_early_coin", n_one - b1, 1);
    check("bottle_early_noret", n_ret - br, 0);

    // Two-dollar coin
    start(t0);
    bus.sense_two = 1'b1;
    to_cyc(t0 + 11); bus.sense_two = 1'b0;
    to_cyc(t0 + 30);
`ifdef COIN_ACCEPTOR_TWO_DOLLAR_EN
    check("two_coin", n_two - b2, 1);
    check("two_latency", last_coin - t0, 5);
    check("two_noret", n_ret - br, 0);
`else
    check("two_nocoin", n_two - b2, 0);
    check("two_ret", n_ret - br, 1);
    check("two_ret_time", last_ret - t0, 5);
`endif
    check("two_no_one", n_one - b1, 0);

    // Jam: both sensors together for 6 samples
    start(t0);
    bus.sense_one = 1'b1;
    bus.sense_two = 1'b1;
    to_cyc(t0 + 1);  check("jam_busy_t1", int'(bus.busy), 0);
    to_cyc(t0 + 2);  check("jam_busy_t2", int'(bus.busy), 1);
    to_cyc(t0 + 5);  bus.sense_one = 1'b0; bus.sense_two = 1'b0;
    to_cyc(t0 + 12); check("jam_busy_gap", int'(bus.busy), 1);
    to_cyc(t0 + 13); check("jam_busy_fall", int'(bus.busy), 0);
    to_cyc(t0 + 30);
    check("jam_ret", n_ret - br, 1);
    check("jam_ret_time", last_ret - t0, 2);
    check("jam_nocoin", (n_one - b1) + (n_two - b2), 0);

    // Reset during DEB, sensor held across reset
    start(t0);
    bus.sense_one = 1'b1;
    to_cyc(t0 + 3);  check("rmid_busy_pre", int'(bus.busy), 1);
    rst = 1'b1;
    to_cyc(t0 + 4);  rst = 1'b0;
    check("rmid_coin", int'(bus.coin), 0);
    check("rmid_ret",  int'(bus.coin_return), 0);
    check("rmid_busy", int'(bus.busy), 0);
    to_cyc(t0 + 16); bus.sense_one = 1'b0;
    to_cyc(t0 + 40);
    check("rmid_count", n_one - b1, 1);
    check("rmid_latency", last_coin - t0, 10);
    check("rmid_noret", n_ret - br, 0);

    check("exclusive_outputs", viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/coin_acceptor.md
# coin_acceptor

Front-end stage of the vending machine: conditions the raw mechanical coin sensors and delivers clean, single-cycle coin codes on `coin[1:0]` to the vending FSM, which counts one-dollar coins and raises `bottle`. Each sensor is synchronised and debounced, and each physical coin produces exactly one pulse. Coins that arrive while a bottle is being dispensed, or that are ambiguous, are rejected through a `coin_return` pulse instead.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronised samples required to accept a press or a release; legal range 2..15.
- `GAP_CYCLES`, default 2: dead cycles after a release before the next coin can be seen; legal range 1..15.

- `clk` in 1: single clock for the block.
- `rst` in 1: synchronous, active-high reset.
- `sense_one` in 1: raw one-dollar sensor, asynchronous, active-high.
- `sense_two` in 1: raw two-dollar sensor, asynchronous, active-high.
- `bottle` in 1: dispense indication fed back from the vending FSM. While it is high, coins are refused.
- `coin` out 2: registered coin code. 0 = none, 1 = one dollar, 2 = two dollar. Code 3 is never driven.
- `coin_return` out 1: registered one-cycle pulse; the coin was rejected.
- `busy` out 1: registered; high whenever the state is not IDLE.

## Operation
- Each sensor passes through two flops (s1, s2). All decisions use the s2 samples, called `one` and `two`.
- States:
  - **IDLE**
    - Exactly one of `one`/`two` is high: latch the type, set cnt=1, go to DEB.
    - Both are high (jam): pulse `coin_return`, go to REL.
  - **DEB**
    - The latched sensor is high and the other is low: cnt++.
    - When cnt==DEBOUNCE_CYCLES-1 and the sample is still high, accept the coin and go to REL.
    - The latched sensor drops, or the other sensor rises: go back to IDLE. No output is produced (this is a glitch).
  - **Accept**
    - If `bottle`==0: `coin` takes the latched code.
    - If `bottle`==1: `coin` stays 0 and `coin_return` is pulsed instead.
  - **REL**
    - Wait until both sensors read low for DEBOUNCE_CYCLES consecutive samples.
    - Any high sample restarts the low count.
    - Then set gap=0 and go to GAP.
  - **GAP**
    - Run GAP_CYCLES cycles ignoring the sensors, then return to IDLE.
- `coin` and `coin_return` are high for exactly one cycle per event and are never high together.
- Counters are 4 bits wide and saturate; the range limits above guarantee they never wrap.
- Reset values:
  - state = IDLE, all counters = 0, s1/s2 = 0.
  - `coin` = 0, `coin_return` = 0, `busy` = 0.
- Reset mid-operation:
  - Any coin in DEB is discarded and no pulse is produced.
  - A sensor still high when reset releases is treated as a fresh coin, because s2 starts at 0.
- `bottle` is sampled only on the accept edge. Its value at any other time has no effect.

## Timing
- Let t0 be the first edge at which s1 captures raw high.
  - s2 is high after t0+1.
  - IDLE→DEB happens at t0+2.
  - Acceptance happens at t0+DEBOUNCE_CYCLES+1.
  - `coin` is high during the cycle after that edge: t0+5 with the defaults. This is the total latency.
- `coin` drops at the following edge, so the vending FSM sees it on exactly one edge.
- Minimum spacing between two accepted coins is 2·DEBOUNCE_CYCLES+GAP_CYCLES+2 cycles from the accept edge, assuming the release starts immediately.
- `busy` rises with the IDLE→DEB (or IDLE→REL) edge and falls with the GAP→IDLE edge.

## Configuration
- The macro is `COIN_ACCEPTOR_TWO_DOLLAR_EN`.
- Defined:
  - The `sense_two` path is fully active.
  - An accepted two-dollar coin drives `coin`=2.
- Undefined:
  - A debounced `sense_two` coin is accepted as a reject.
  - It produces a `coin_return` pulse and `coin`=0.
  - All timing is identical to the defined case.
- The jam rule (both sensors high) applies in both builds.

## Test plan
- **Clean one-dollar coin.** Defaults; `sense_one` high 12 cycles from t0 → `coin`=1 for one cycle after edge t0+5; `busy` high from t0+2 until REL+GAP complete.
- **Glitch.** `sense_one` high 2 cycles, then low → no `coin`, no `coin_return`; state returns to IDLE.
- **Refused during dispense.** `bottle`=1 across the accept edge for a clean one-dollar coin → `coin_return`=1 for one cycle, `coin` stays 0.
- **Two-dollar coin.** `sense_two` high 12 cycles → `coin`=2 with the macro defined; `coin_return`=1 and `coin`=0 without it.
- **Jam.** Both sensors high together → one `coin_return` pulse; no further pulses until both sensors are released for 4 samples plus the 2 gap cycles.
- **Reset mid-coin.** `rst` asserted 1 cycle during DEB → outputs 0, no pulse. A sensor held high across reset yields exactly one `coin`=1 pulse, at 5 cycles after the first edge at which s1 captures high after reset.
